// File: rtl/booth2_pkg.sv
// Shared radix-4 Booth digit definitions, common to the encoder and decoder sides.
package booth2_pkg;

    typedef logic [2:0] booth2_digit_t;

    localparam booth2_digit_t B2_ZERO = 3'b000;
    localparam booth2_digit_t B2_P1   = 3'b001;
    localparam booth2_digit_t B2_P2   = 3'b010;
    localparam booth2_digit_t B2_M2   = 3'b110;
    localparam booth2_digit_t B2_M1   = 3'b111;

    typedef enum logic {
        COLLECT,
        HOLD
    } booth2_state_t;

endpackage

// File: rtl/booth2_digit_value.sv
// Maps a 3-bit Booth digit code to its signed value and flags codes outside the legal set.
module booth2_digit_value
    import booth2_pkg::*;
(
    input  booth2_digit_t      i_code,
    output logic signed [2:0]  o_value,
    output logic               o_illegal
);

    always_comb begin
        o_value   = signed'(i_code);
        o_illegal = 1'b1;
        case (i_code)
            B2_ZERO, B2_P1, B2_P2, B2_M1, B2_M2: o_illegal = 1'b0;
            default:                             o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth2_digit_decoder.sv
// Serial radix-4 Booth digit decoder: rebuilds a WIDTH-bit operand from NDIG digits, LSB first.
// Define BOOTH2_DEC_CHECK_EN to zero and flag illegal digit codes via out_err.
module booth2_digit_decoder
    import booth2_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_digit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int NDIG  = WIDTH / 2;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    booth2_state_t            r_state;
    logic [IDX_W-1:0]         r_idx;
    logic signed [WIDTH+1:0]  r_acc;
    logic                     r_err;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [WIDTH-1:0]         r_out_value;
    logic                     r_out_ovf;
    logic                     r_out_err;

    logic signed [2:0]        w_raw;
    logic                     w_illegal;
    logic signed [2:0]        w_dval;
    logic                     w_chk_illegal;
    logic signed [WIDTH+1:0]  w_dsext;
    logic signed [WIDTH+1:0]  w_term;
    logic signed [WIDTH+1:0]  w_acc_nxt;
    logic [2:0]               w_top;
    logic                     w_ovf;
    logic                     w_err_nxt;

    booth2_digit_value u_dval (
        .i_code    (in_digit),
        .o_value   (w_raw),
        .o_illegal (w_illegal)
    );

`ifdef BOOTH2_DEC_CHECK_EN
    assign w_chk_illegal = w_illegal;
    assign w_dval        = w_illegal ? 3'sd0 : w_raw;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
    assign w_chk_illegal    = 1'b0;
    assign w_dval           = w_raw;
`endif

    // Digit weight is 4^idx; WIDTH+2 bits cover the full Booth range without wrap.
    assign w_dsext   = {{(WIDTH-1){w_dval[2]}}, w_dval};
    assign w_term    = w_dsext <<< {r_idx, 1'b0};
    assign w_acc_nxt = r_acc + w_term;
    assign w_top     = w_acc_nxt[WIDTH+1:WIDTH-1];
    assign w_ovf     = !((w_top == '0) || (w_top == '1));
    assign w_err_nxt = r_err | w_chk_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_ovf   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        r_acc <= w_acc_nxt;
                        r_err <= w_err_nxt;
                        if (r_idx == LAST_IDX) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_value <= w_acc_nxt[WIDTH-1:0];
                            r_out_ovf   <= w_ovf;
                            r_out_err   <= w_err_nxt;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= COLLECT;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_value <= '0;
                        r_out_ovf   <= 1'b0;
                        r_out_err   <= 1'b0;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_ovf   = r_out_ovf;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_booth2_digit_decoder.sv
// Self-checking bench for booth2_digit_decoder at WIDTH=8: per-cycle arithmetic model plus directed literals.
module tb_booth2_digit_decoder;

    localparam int W    = 8;
    localparam int NDIG = W / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_digit = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_value;
    logic         out_ovf;
    logic         out_err;

    int n_pass  = 0;
    int n_total = 0;

    booth2_digit_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_illegal(input logic [2:0] c);
        return (c == 3'd3) || (c == 3'd4) || (c == 3'd5);
    endfunction

    function automatic int dig_val(input logic [2:0] c);
        int v;
        v = (c >= 3'd4) ? int'(c) - 8 : int'(c);
`ifdef BOOTH2_DEC_CHECK_EN
        if (is_illegal(c)) v = 0;
`endif
        return v;
    endfunction

    // Reference model: plain weighted sum of digit values.
    bit           m_hold = 1'b0;
    int           m_cnt  = 0;
    int           m_sum  = 0;
    bit           m_err  = 1'b0;
    logic [W-1:0] e_value;
    bit           e_ovf;
    bit           e_err;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_value", 32'(out_value), 32'd0);
            chk("rst_out_ovf",   32'(out_ovf),   32'd0);
            chk("rst_out_err",   32'(out_err),   32'd0);
            m_hold = 1'b0; m_cnt = 0; m_sum = 0; m_err = 1'b0;
        end else begin
            chk("in_ready",  32'(in_ready),  32'(!m_hold));
            chk("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                chk("out_value", 32'(out_value), 32'(e_value));
                chk("out_ovf",   32'(out_ovf),   32'(e_ovf));
                chk("out_err",   32'(out_err),   32'(e_err));
            end else begin
                chk("out_err_idle", 32'(out_err), 32'd0);
            end
            if (!m_hold && in_valid) begin
                m_sum += dig_val(in_digit) * (4 ** m_cnt);
`ifdef BOOTH2_DEC_CHECK_EN
                m_err |= is_illegal(in_digit);
`endif
                m_cnt++;
                if (m_cnt == NDIG) begin
                    m_hold  = 1'b1;
                    e_value = W'(m_sum);
                    e_ovf   = (m_sum > 127) || (m_sum < -128);
                    e_err   = m_err;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0; m_cnt = 0; m_sum = 0; m_err = 1'b0;
            end
        end
    end

    task automatic send_digit(input logic [2:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_digit = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] d0, input logic [2:0] d1,
                          input logic [2:0] d2, input logic [2:0] d3,
                          input logic [W-1:0] ev, input bit eo, input bit ee,
                          input string name);
        send_digit(d0);
        send_digit(d1);
        send_digit(d2);
        send_digit(d3);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_value"}, 32'(out_value), 32'(ev));
        chk({name, "_ovf"},   32'(out_ovf),   32'(eo));
        chk({name, "_err"},   32'(out_err),   32'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        run_op(3'b110, 3'b111, 3'b010, 3'b001, 8'h5A, 1'b0, 1'b0, "op90");
        run_op(3'b000, 3'b000, 3'b000, 3'b110, 8'h80, 1'b0, 1'b0, "opm128");
        run_op(3'b010, 3'b010, 3'b010, 3'b010, 8'hAA, 1'b1, 1'b0, "op170");

        // Backpressure: result held, incoming digit must not be consumed.
        out_ready = 1'b0;
        run_op(3'b010, 3'b010, 3'b010, 3'b010, 8'hAA, 1'b1, 1'b0, "bp_op");
        in_valid = 1'b1;
        in_digit = 3'b001;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_value",    32'(out_value), 32'hAA);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'b001, 3'b001, 3'b001, 3'b001, 8'h55, 1'b0, 1'b0, "op85");

        send_digit(3'b001);
        send_digit(3'b010);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        run_op(3'b001, 3'b000, 3'b000, 3'b000, 8'h01, 1'b0, 1'b0, "op1");

`ifdef BOOTH2_DEC_CHECK_EN
        run_op(3'b011, 3'b001, 3'b000, 3'b000, 8'h04, 1'b0, 1'b1, "illegal");
`else
        run_op(3'b011, 3'b001, 3'b000, 3'b000, 8'h07, 1'b0, 1'b0, "illegal");
`endif
        run_op(3'b001, 3'b001, 3'b000, 3'b000, 8'h05, 1'b0, 1'b0, "clean");

        repeat (500) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_digit  = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/booth2_digit_decoder.md
Name: booth2_digit_decoder

Overview:
- Serial inverse of the radix-4 Booth encoder: accepts one 3-bit signed Booth digit per handshake, LSB digit first, and rebuilds the WIDTH-bit two's-complement multiplier value.
- Used as a checker and reconstructor beside the Booth multiplier datapath, so that encoder output streams can be compared against the original operand.
- Flags values that cannot be represented in WIDTH bits and illegal digit codes.

Parameters:
- WIDTH, 16, reconstructed operand width. Must be even and ≥ 4.
- NDIG, WIDTH/2, digits per operand. Derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  digit present
- in_ready  out  1  decoder can accept a digit
- in_digit  in  3  Booth digit, two's complement. Legal codes: 000=0, 001=+1, 010=+2, 110=−2, 111=−1.
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_value  out  WIDTH  reconstructed value, two's complement
- out_ovf  out  1  sum outside signed WIDTH range
- out_err  out  1  an illegal code was seen in this operand (only with the optional feature)

Behaviour:
- Reset values: all outputs 0, except in_ready=1 once reset deasserts. Accumulator 0, digit index 0, state COLLECT.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Digit accept: in_valid&in_ready on a clock edge.
  - acc <= acc + (sext(d) << 2*idx), with acc signed WIDTH+2 bits.
  - idx increments.
- Transition COLLECT→HOLD: when the accepted digit has idx==NDIG−1. Result registered on that edge, so out_valid rises on the cycle after the last accept (latency 1).
- Output in HOLD:
  - out_value = acc[WIDTH−1:0].
  - out_ovf = 1 iff acc[WIDTH+1:WIDTH−1] is not all-equal.
  - All outputs stay stable until handshake.
- Transition HOLD→COLLECT: on out_valid&out_ready. acc, idx and err are cleared. in_ready rises the next cycle; there is no same-cycle pass-through.
- in_valid during HOLD is ignored; the digit is not consumed.
- out_ready held high causes back-to-back operands to cost NDIG+1 cycles each.
- idx wraps only via the HOLD exit. It never exceeds NDIG−1.
- rst asserted mid-operand drops the partial sum immediately (asynchronous). Any in-flight digit is lost.
- Range guarantee: |acc| ≤ 2·(4^NDIG−1)/3 < 2^WIDTH, so WIDTH+2 bits never wrap.

Optional Feature:
- Macro: BOOTH2_DEC_CHECK_EN.
- Defined:
  - Codes 011, 100 and 101 set a sticky err register and contribute 0 to acc.
  - out_err = err while in HOLD, 0 otherwise.
- Undefined:
  - No check logic.
  - out_err is tied to 0.
  - Illegal codes are added as their raw signed value (+3, −4, −3).

Decomposition:
- Shared package booth2_pkg:
  - 3-bit digit typedef.
  - Localparams for the five legal codes: B2_ZERO, B2_P1, B2_P2, B2_M1, B2_M2.
  - A state enum {COLLECT, HOLD}.
  - These are shared with the encoder side.
- One combinational sub-module, booth2_digit_value:
  - Maps a code to a 3-bit signed value plus an illegal flag.
  - The illegal flag is unused when the macro is off.
- Top level holds the FSM, idx counter and accumulator.

Test Plan (WIDTH=8, NDIG=4):
- Digits 110,111,010,001 with out_ready=1 → out_valid one cycle after 4th accept; out_value=8'h5A (90); out_ovf=0; out_err=0.
- Digits 000,000,000,110 → out_value=8'h80 (−128); out_ovf=0.
- Digits 010 ×4 → acc=170; out_value=8'hAA; out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles after result, in_valid held high with 001 → in_ready=0, out_value stable, no digit consumed. Release out_ready → next operand 001 ×4 gives out_value=8'h55 (85).
- rst pulse after 2 digits accepted → out_valid=0 and in_ready=1 after deassertion. A new 4-digit sequence 001,000,000,000 gives out_value=1.
- With BOOTH2_DEC_CHECK_EN: digits 011,001,000,000 → out_value=4, out_err=1. The next clean operand gives out_err=0. Without the macro the same digits give out_value=7, out_err=0.
